evo_scheduler: RTL and testbench
================================

// Module: evo_scheduler
// PURPOSE
//  Sequences the Game-of-Life datapath between the keyboard controller and the evolution engine, cell RAM and file loader.
//  Converts held start/pause/clear/reload/modify levels into one-shot actions: timed generation steps, full-RAM clear sweeps,
//  file loads and single-cell manual edits. Sole owner of step timing, so exactly one datapath operation is in flight at a time.
// PARAMETERS
//  P_PARAM_N    64  grid width in cells
//  P_PARAM_M    64  grid height in cells
//  WIDTH        12  coordinate width; addresses are 2*WIDTH bits
//  BASE_PERIOD  2_500_000  clk_in cycles between steps at evo_left_shift=0 (50 ms @50 MHz)
//  TICK_W       32  tick counter width; must hold BASE_PERIOD<<5
// PORTS
//  clk_in        in   1        50 MHz clock
//  reset         in   1        asynchronous, active-high reset
//  start         in   1        level from keyboard ctrl; rising edge = run
//  pause         in   1        level; rising edge = pause
//  clear         in   1        level; rising edge = clear grid + reload
//  manual        in   1        manual-edit mode enable (level)
//  modify        in   1        level; rising edge = toggle cell at setting_pos
//  setting_pos   in   2*WIDTH  linear cell address for manual edit
//  file_id       in   16       selected pattern file
//  evo_left_shift in  4        speed: period = BASE_PERIOD << min(evo_left_shift,5)
//  step_done     in   1        evolution engine finished one generation (1-cycle pulse)
//  load_done     in   1        loader finished writing pattern (1-cycle pulse)
//  step_req      out  1        1-cycle pulse: compute one generation
//  load_req      out  1        1-cycle pulse: load pattern load_file_id
//  load_file_id  out  16       file_id latched when load_req issued
//  clr_we        out  1        clear-sweep write enable (data 0)
//  clr_addr      out  2*WIDTH  clear-sweep address
//  edit_we       out  1        1-cycle toggle-write enable
//  edit_addr     out  2*WIDTH  setting_pos latched on edit
//  busy          out  1        high in CLEAR, LOAD, STEP
//  gen_count     out  16       generations since last clear/load, wraps FFFF->0
//  state         out  3        current state encoding (debug / LED)
// BEHAVIOUR
//  Reset: all outputs 0, state=IDLE, tick=0, pending flags cleared, edge detectors' previous-value regs=0; holds mid-operation too.
//  All outputs registered. Edge detect = input & ~prev, one cycle after input rises. Held levels never retrigger.
//  States: IDLE=0 LOAD=1 RUN_WAIT=2 STEP=3 PAUSED=4 CLEAR=5 EDIT=6.
//  IDLE/PAUSED priority, highest first: clear_rise->CLEAR; file_id!=load_file_id->LOAD;
//   start_rise->RUN_WAIT (tick=0); manual&modify_rise->EDIT. pause_rise in IDLE ignored.
//  RUN_WAIT: tick++ each cycle; when tick>=period-1 -> STEP, step_req=1 that cycle, tick=0.
//   Uses live evo_left_shift; lowering it below current tick steps next cycle. pause_rise->PAUSED, tick held.
//   clear_rise->CLEAR. modify and file_id changes ignored.
//  STEP: never aborted. pause_rise/clear_rise latched into pend_pause/pend_clear.
//   On step_done: gen_count++, then pend_clear->CLEAR, else pend_pause->PAUSED, else RUN_WAIT; pend flags cleared.
//  CLEAR: clr_we=1, clr_addr 0..N*M-1 one per cycle, no gaps; after last address -> LOAD; gen_count=0.
//  LOAD: load_req=1 on first cycle, load_file_id=file_id; stay until load_done -> IDLE, gen_count=0.
//  EDIT: single cycle; edit_we=1, edit_addr=setting_pos sampled on modify_rise; return to originating IDLE/PAUSED.
//  step_done/load_done outside STEP/LOAD ignored. start_rise outside IDLE/PAUSED ignored.
//  busy=1 exactly in CLEAR, LOAD, STEP.
// TESTING (BASE_PERIOD=4, N=M=4)
//  start rises at cycle t, shift=0 -> RUN_WAIT t+1; step_req single pulse t+5; step_done at t+7 -> gen_count=1, next step_req t+12.
//  shift=2, running -> step_req pulses spaced 16 cycles + step latency; shift 2->0 mid-wait with tick=9 -> step_req next cycle.
//  pause rises during STEP -> no abort; on step_done gen_count increments, state=PAUSED, no further step_req; start resumes.
//  clear rises in RUN_WAIT -> clr_we 16 consecutive cycles addr 0..15, load_req pulse, gen_count=0; load_done -> IDLE.
//  PAUSED, manual=1, setting_pos=5, modify rises -> edit_we 1 cycle addr 5, back to PAUSED; same with manual=0 or in RUN_WAIT -> no edit_we.
//  reset asserted at clr_addr=7 -> all outputs 0 asynchronously, state=IDLE; after release no residual writes.

Source files
------------

// File: rtl/evo_scheduler.sv
// Game-of-Life datapath sequencer: turns keyboard levels into one-shot step, clear, load and edit
// operations. At most one datapath operation is in flight at any time.
module evo_scheduler #(
    parameter int P_PARAM_N   = 64,
    parameter int P_PARAM_M   = 64,
    parameter int WIDTH       = 12,
    parameter int BASE_PERIOD = 2_500_000,
    parameter int TICK_W      = 32
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 clear,
    input  logic                 manual,
    input  logic                 modify,
    input  logic [2*WIDTH-1:0]   setting_pos,
    input  logic [15:0]          file_id,
    input  logic [3:0]           evo_left_shift,
    input  logic                 step_done,
    input  logic                 load_done,
    output logic                 step_req,
    output logic                 load_req,
    output logic [15:0]          load_file_id,
    output logic                 clr_we,
    output logic [2*WIDTH-1:0]   clr_addr,
    output logic                 edit_we,
    output logic [2*WIDTH-1:0]   edit_addr,
    output logic                 busy,
    output logic [15:0]          gen_count,
    output logic [2:0]           state
);

    localparam int AW    = 2 * WIDTH;
    localparam int CELLS = P_PARAM_N * P_PARAM_M;
    localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_RUN_WAIT = 3'd2,
        S_STEP     = 3'd3,
        S_PAUSED   = 3'd4,
        S_CLEAR    = 3'd5,
        S_EDIT     = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic                pend_pause_q, pend_pause_d;
    logic                pend_clear_q, pend_clear_d;
    logic                ret_paused_q, ret_paused_d;
    logic                start_prev_q, pause_prev_q, clear_prev_q, modify_prev_q;
    logic                step_req_q, step_req_d;
    logic                load_req_q, load_req_d;
    logic [15:0]         load_file_id_q, load_file_id_d;
    logic                clr_we_q, clr_we_d;
    logic [AW-1:0]       clr_addr_q, clr_addr_d;
    logic                edit_we_q, edit_we_d;
    logic [AW-1:0]       edit_addr_q, edit_addr_d;
    logic                busy_q, busy_d;
    logic [15:0]         gen_q, gen_d;

    logic                start_rise_s, pause_rise_s, clear_rise_s, modify_rise_s;
    logic [2:0]          shift_sat_s;
    logic [TICK_W-1:0]   period_s;

    assign start_rise_s  = start  & ~start_prev_q;
    assign pause_rise_s  = pause  & ~pause_prev_q;
    assign clear_rise_s  = clear  & ~clear_prev_q;
    assign modify_rise_s = modify & ~modify_prev_q;

    // Speed saturates at a 32x slowdown; evaluated live so a speed-up mid-wait takes effect at once.
    assign shift_sat_s = (evo_left_shift > 4'd5) ? 3'd5 : evo_left_shift[2:0];
    assign period_s    = TICK_W'(BASE_PERIOD) << shift_sat_s;

    // Next-state and registered-output logic
    always_comb begin
        state_d        = state_q;
        tick_d         = tick_q;
        pend_pause_d   = pend_pause_q;
        pend_clear_d   = pend_clear_q;
        ret_paused_d   = ret_paused_q;
        step_req_d     = 1'b0;
        load_req_d     = 1'b0;
        load_file_id_d = load_file_id_q;
        clr_we_d       = 1'b0;
        clr_addr_d     = clr_addr_q;
        edit_we_d      = 1'b0;
        edit_addr_d    = edit_addr_q;
        gen_d          = gen_q;

        case (state_q)
            S_IDLE, S_PAUSED: begin
                if (clear_rise_s) begin
                    state_d    = S_CLEAR;
                    clr_we_d   = 1'b1;
                    clr_addr_d = {AW{1'b0}};
                end else if (file_id != load_file_id_q) begin
                    state_d        = S_LOAD;
                    load_req_d     = 1'b1;
                    load_file_id_d = file_id;
                end else if (start_rise_s) begin
                    state_d = S_RUN_WAIT;
                    tick_d  = {TICK_W{1'b0}};
                end else if (manual && modify_rise_s) begin
                    state_d      = S_EDIT;
                    edit_we_d    = 1'b1;
                    edit_addr_d  = setting_pos;
                    ret_paused_d = (state_q == S_PAUSED);
                end else begin
                    state_d = state_q;
                end
            end
            S_RUN_WAIT: begin
                if (clear_rise_s) begin
                    state_d    = S_CLEAR;
                    clr_we_d   = 1'b1;
                    clr_addr_d = {AW{1'b0}};
                end else if (pause_rise_s) begin
                    state_d = S_PAUSED;
                end else if (tick_q >= period_s - TICK_W'(1)) begin
                    state_d      = S_STEP;
                    step_req_d   = 1'b1;
                    tick_d       = {TICK_W{1'b0}};
                    pend_pause_d = 1'b0;
                    pend_clear_d = 1'b0;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            S_STEP: begin
                // A request arriving in the completion cycle itself still counts as pending.
                if (step_done) begin
                    gen_d        = gen_q + 16'd1;
                    pend_pause_d = 1'b0;
                    pend_clear_d = 1'b0;
                    if (pend_clear_q || clear_rise_s) begin
                        state_d    = S_CLEAR;
                        clr_we_d   = 1'b1;
                        clr_addr_d = {AW{1'b0}};
                    end else if (pend_pause_q || pause_rise_s) begin
                        state_d = S_PAUSED;
                    end else begin
                        state_d = S_RUN_WAIT;
                        tick_d  = {TICK_W{1'b0}};
                    end
                end else begin
                    pend_pause_d = pend_pause_q | pause_rise_s;
                    pend_clear_d = pend_clear_q | clear_rise_s;
                end
            end
            S_CLEAR: begin
                if (clr_addr_q == LAST_ADDR) begin
                    state_d        = S_LOAD;
                    load_req_d     = 1'b1;
                    load_file_id_d = file_id;
                    gen_d          = 16'd0;
                end else begin
                    clr_we_d   = 1'b1;
                    clr_addr_d = clr_addr_q + AW'(1);
                end
            end
            S_LOAD: begin
                if (load_done) begin
                    state_d = S_IDLE;
                    gen_d   = 16'd0;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_EDIT: begin
                state_d = ret_paused_q ? S_PAUSED : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_CLEAR) || (state_d == S_LOAD) || (state_d == S_STEP);
    end

    // State and output registers
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            tick_q         <= {TICK_W{1'b0}};
            pend_pause_q   <= 1'b0;
            pend_clear_q   <= 1'b0;
            ret_paused_q   <= 1'b0;
            start_prev_q   <= 1'b0;
            pause_prev_q   <= 1'b0;
            clear_prev_q   <= 1'b0;
            modify_prev_q  <= 1'b0;
            step_req_q     <= 1'b0;
            load_req_q     <= 1'b0;
            load_file_id_q <= 16'd0;
            clr_we_q       <= 1'b0;
            clr_addr_q     <= {AW{1'b0}};
            edit_we_q      <= 1'b0;
            edit_addr_q    <= {AW{1'b0}};
            busy_q         <= 1'b0;
            gen_q          <= 16'd0;
        end else begin
            state_q        <= state_d;
            tick_q         <= tick_d;
            pend_pause_q   <= pend_pause_d;
            pend_clear_q   <= pend_clear_d;
            ret_paused_q   <= ret_paused_d;
            start_prev_q   <= start;
            pause_prev_q   <= pause;
            clear_prev_q   <= clear;
            modify_prev_q  <= modify;
            step_req_q     <= step_req_d;
            load_req_q     <= load_req_d;
            load_file_id_q <= load_file_id_d;
            clr_we_q       <= clr_we_d;
            clr_addr_q     <= clr_addr_d;
            edit_we_q      <= edit_we_d;
            edit_addr_q    <= edit_addr_d;
            busy_q         <= busy_d;
            gen_q          <= gen_d;
        end
    end

    assign step_req     = step_req_q;
    assign load_req     = load_req_q;
    assign load_file_id = load_file_id_q;
    assign clr_we       = clr_we_q;
    assign clr_addr     = clr_addr_q;
    assign edit_we      = edit_we_q;
    assign edit_addr    = edit_addr_q;
    assign busy         = busy_q;
    assign gen_count    = gen_q;
    assign state        = state_q;

endmodule

// File: tb/tb_evo_scheduler.sv
// Directed bench for evo_scheduler with a 4x4 grid and a 4-cycle base step period.
module tb_evo_scheduler;

    localparam int WIDTH = 2;
    localparam int AW    = 2 * WIDTH;

    logic            clk_in = 1'b0;
    logic            reset;
    logic            start, pause, clear, manual, modify;
    logic [AW-1:0]   setting_pos;
    logic [15:0]     file_id;
    logic [3:0]      evo_left_shift;
    logic            step_done, load_done;
    logic            step_req, load_req, clr_we, edit_we, busy;
    logic [15:0]     load_file_id, gen_count;
    logic [AW-1:0]   clr_addr, edit_addr;
    logic [2:0]      state;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic          st, pa, cl, ma, mo, sd;
        logic [AW-1:0] pos;
        logic [2:0]    e_state;
        logic          e_step, e_edit, e_busy;
        logic [15:0]   e_gen;
        logic [AW-1:0] e_eaddr;
    } vec_t;

    vec_t tbl[30];

    evo_scheduler #(
        .P_PARAM_N(4), .P_PARAM_M(4), .WIDTH(WIDTH), .BASE_PERIOD(4), .TICK_W(8)
    ) dut (
        .clk_in(clk_in), .reset(reset), .start(start), .pause(pause), .clear(clear),
        .manual(manual), .modify(modify), .setting_pos(setting_pos), .file_id(file_id),
        .evo_left_shift(evo_left_shift), .step_done(step_done), .load_done(load_done),
        .step_req(step_req), .load_req(load_req), .load_file_id(load_file_id),
        .clr_we(clr_we), .clr_addr(clr_addr), .edit_we(edit_we), .edit_addr(edit_addr),
        .busy(busy), .gen_count(gen_count), .state(state)
    );

    always #5 clk_in = ~clk_in;

    function automatic vec_t v(input logic st, pa, cl, ma, mo, sd, input logic [AW-1:0] pos,
                               input logic [2:0] es, input logic estep, eedit, ebusy,
                               input logic [15:0] egen, input logic [AW-1:0] eaddr);
        vec_t r;
        r.st = st; r.pa = pa; r.cl = cl; r.ma = ma; r.mo = mo; r.sd = sd; r.pos = pos;
        r.e_state = es; r.e_step = estep; r.e_edit = eedit; r.e_busy = ebusy;
        r.e_gen = egen; r.e_eaddr = eaddr;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled at the next falling edge.
    task automatic cyc();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic wait_step_req(input int budget, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (step_req !== 1'b1 && n < budget);
        if (step_req !== 1'b1) chk("step_req_timeout", 32'(step_req), 32'd1);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0; manual = 1'b0; modify = 1'b0;
        setting_pos = '0; file_id = 16'd0; evo_left_shift = 4'd0; step_done = 1'b0; load_done = 1'b0;

        //            st pa cl ma mo sd pos   state step edit busy gen eaddr
        tbl[0]  = v(0, 0, 0, 0, 0, 0, 4'd0, 3'd0, 0, 0, 0, 16'd0, 4'd0);
        tbl[1]  = v(0, 1, 0, 0, 0, 0, 4'd0, 3'd0, 0, 0, 0, 16'd0, 4'd0);
        tbl[2]  = v(0, 0, 0, 0, 0, 0, 4'd0, 3'd0, 0, 0, 0, 16'd0, 4'd0);
        tbl[3]  = v(1, 0, 0, 0, 0, 0, 4'd0, 3'd2, 0, 0, 0, 16'd0, 4'd0);
        tbl[4]  = v(0, 0, 0, 0, 0, 0, 4'd0, 3'd2, 0, 0, 0, 16'd0, 4'd0);
        tbl[5]  = v(0, 0, 0, 0, 0, 0, 4'd0, 3'd2, 0, 0, 0, 16'd0, 4'd0);
        tbl[6]  = v(0, 0, 0, 0, 0, 0, 4'd0, 3'd2, 0, 0, 0, 16'd0, 4'd0);
        tbl[7]  = v(0, 0, 0, 0, 0, 0, 4'd0, 3'd3, 1, 0, 1, 16'd0, 4'd0);
        tbl[8]  = v(0, 0, 0, 0, 0, 0, 4'd0, 3'd3, 0, 0, 1, 16'd0, 4'd0);
        tbl[9]  = v(0, 0, 0, 0, 0, 1, 4'd0, 3'd2, 0, 0, 0, 16'd1, 4'd0);
        tbl[10] = v(0, 0, 0, 0, 0, 0, 4'd0, 3'd2, 0, 0, 0, 16'd1, 4'd0);
        tbl[11] = v(0, 0, 0, 0, 0, 0, 4'd0, 3'd2, 0, 0, 0, 16'd1, 4'd0);
        tbl[12] = v(0, 0, 0, 0, 0, 0, 4'd0, 3'd2, 0, 0, 0, 16'd1, 4'd0);
        tbl[13] = v(0, 0, 0, 0, 0, 0, 4'd0, 3'd3, 1, 0, 1, 16'd1, 4'd0);
        tbl[14] = v(0, 1, 0, 0, 0, 0, 4'd0, 3'd3, 0, 0, 1, 16'd1, 4'd0);
        tbl[15] = v(0, 0, 0, 0, 0, 1, 4'd0, 3'd4, 0, 0, 0, 16'd2, 4'd0);
        tbl[16] = v(0, 0, 0, 0, 0, 0, 4'd0, 3'd4, 0, 0, 0, 16'd2, 4'd0);
        tbl[17] = v(0, 0, 0, 0, 0, 0, 4'd0, 3'd4, 0, 0, 0, 16'd2, 4'd0);
        tbl[18] = v(1, 0, 0, 0, 0, 0, 4'd0, 3'd2, 0, 0, 0, 16'd2, 4'd0);
        tbl[19] = v(0, 0, 0, 1, 1, 0, 4'd3, 3'd2, 0, 0, 0, 16'd2, 4'd0);
        tbl[20] = v(0, 0, 0, 1, 0, 0, 4'd0, 3'd2, 0, 0, 0, 16'd2, 4'd0);
        tbl[21] = v(0, 0, 0, 0, 0, 0, 4'd0, 3'd2, 0, 0, 0, 16'd2, 4'd0);
        tbl[22] = v(0, 0, 0, 0, 0, 0, 4'd0, 3'd3, 1, 0, 1, 16'd2, 4'd0);
        tbl[23] = v(0, 1, 0, 0, 0, 0, 4'd0, 3'd3, 0, 0, 1, 16'd2, 4'd0);
        tbl[24] = v(0, 0, 0, 0, 0, 1, 4'd0, 3'd4, 0, 0, 0, 16'd3, 4'd0);
        tbl[25] = v(0, 0, 0, 1, 1, 0, 4'd5, 3'd6, 0, 1, 0, 16'd3, 4'd5);
        tbl[26] = v(0, 0, 0, 1, 1, 0, 4'd5, 3'd4, 0, 0, 0, 16'd3, 4'd5);
        tbl[27] = v(0, 0, 0, 0, 0, 0, 4'd0, 3'd4, 0, 0, 0, 16'd3, 4'd5);
        tbl[28] = v(0, 0, 0, 0, 1, 0, 4'd9, 3'd4, 0, 0, 0, 16'd3, 4'd5);
        tbl[29] = v(0, 0, 0, 0, 0, 0, 4'd0, 3'd4, 0, 0, 0, 16'd3, 4'd5);

        repeat (2) @(negedge clk_in);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_gen", 32'(gen_count), 32'd0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            start = tbl[i].st; pause = tbl[i].pa; clear = tbl[i].cl;
            manual = tbl[i].ma; modify = tbl[i].mo; step_done = tbl[i].sd;
            setting_pos = tbl[i].pos;
            cyc();
            chk($sformatf("row%0d_state", i), 32'(state), 32'(tbl[i].e_state));
            chk($sformatf("row%0d_step_req", i), 32'(step_req), 32'(tbl[i].e_step));
            chk($sformatf("row%0d_edit_we", i), 32'(edit_we), 32'(tbl[i].e_edit));
            chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("row%0d_gen", i), 32'(gen_count), 32'(tbl[i].e_gen));
            chk($sformatf("row%0d_edit_addr", i), 32'(edit_addr), 32'(tbl[i].e_eaddr));
            chk($sformatf("row%0d_clr_we", i), 32'(clr_we), 32'd0);
        end
        start = 1'b0; pause = 1'b0; manual = 1'b0; modify = 1'b0; step_done = 1'b0;

        // Clear from RUN_WAIT: 16-address sweep, then load, then back to IDLE.
        start = 1'b1; cyc(); start = 1'b0;
        chk("clr_pre_state", 32'(state), 32'd2);
        clear = 1'b1; cyc(); clear = 1'b0;
        chk("clr_state", 32'(state), 32'd5);
        chk("clr_we0", 32'(clr_we), 32'd1);
        chk("clr_addr0", 32'(clr_addr), 32'd0);
        for (int i = 1; i < 16; i++) begin
            cyc();
            chk($sformatf("clr_addr%0d", i), 32'(clr_addr), 32'(i));
            chk($sformatf("clr_we%0d", i), 32'(clr_we), 32'd1);
        end
        cyc();
        chk("load_state", 32'(state), 32'd1);
        chk("load_req", 32'(load_req), 32'd1);
        chk("load_clr_we", 32'(clr_we), 32'd0);
        chk("load_gen", 32'(gen_count), 32'd0);
        chk("load_busy", 32'(busy), 32'd1);
        cyc();
        chk("load_req_pulse", 32'(load_req), 32'd0);
        chk("load_hold", 32'(state), 32'd1);
        cyc();
        load_done = 1'b1; cyc(); load_done = 1'b0;
        chk("load_done_state", 32'(state), 32'd0);
        chk("load_done_busy", 32'(busy), 32'd0);

        // Speed shift 2: 16-cycle waits; then a speed-up with tick=9 steps at once.
        evo_left_shift = 4'd2;
        start = 1'b1; cyc(); start = 1'b0;
        wait_step_req(40, n);
        chk("shift2_first_wait", 32'(n), 32'd16);
        cyc();
        step_done = 1'b1; cyc(); step_done = 1'b0;
        wait_step_req(40, n);
        chk("shift2_second_wait", 32'(n), 32'd16);
        cyc();
        step_done = 1'b1; cyc(); step_done = 1'b0;
        repeat (9) cyc();
        chk("tick9_no_step", 32'(step_req), 32'd0);
        chk("tick9_state", 32'(state), 32'd2);
        evo_left_shift = 4'd0;
        cyc();
        chk("speedup_step_req", 32'(step_req), 32'd1);
        chk("speedup_state", 32'(state), 32'd3);
        cyc();
        step_done = 1'b1; cyc(); step_done = 1'b0;
        chk("gen_after_steps", 32'(gen_count), 32'd3);

        // Asynchronous reset in the middle of a clear sweep.
        clear = 1'b1; cyc(); clear = 1'b0;
        repeat (7) cyc();
        chk("mid_clr_addr", 32'(clr_addr), 32'd7);
        #2 reset = 1'b1;
        #1;
        chk("areset_state", 32'(state), 32'd0);
        chk("areset_clr_we", 32'(clr_we), 32'd0);
        chk("areset_clr_addr", 32'(clr_addr), 32'd0);
        chk("areset_busy", 32'(busy), 32'd0);
        chk("areset_gen", 32'(gen_count), 32'd0);
        chk("areset_edit_addr", 32'(edit_addr), 32'd0);
        repeat (3) @(negedge clk_in);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk($sformatf("post_reset_clr_we%0d", i), 32'(clr_we), 32'd0);
            chk($sformatf("post_reset_state%0d", i), 32'(state), 32'd0);
        end

        // A new file selection in IDLE triggers a load of that file.
        file_id = 16'h0003;
        cyc();
        chk("file_load_state", 32'(state), 32'd1);
        chk("file_load_req", 32'(load_req), 32'd1);
        chk("file_load_id", 32'(load_file_id), 32'h3);
        load_done = 1'b1; cyc(); load_done = 1'b0;
        chk("file_load_idle", 32'(state), 32'd0);
        cyc();
        chk("file_no_reload", 32'(state), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
